// File: rtl/ht_pkg.sv
// -----------------------------------------------------------------------------
// ht_pkg
// Shared constants for the ISO 11172-3 Huffman table 8 encoder and decoder.
//   - HT8_CODE / HT8_LEN : codeword and codeword length, indexed by |x|*6+|y|
//   - HT8_MAX_BITS       : longest table-8 codeword in bits
//   - HT8_LINBITS        : linbits for table 8 (none; no escape field exists)
//   - ht8_state_t        : encoder serialiser states
//   - ht8_index()        : (|x|,|y|) -> flat table index
// -----------------------------------------------------------------------------
package ht_pkg;

    localparam int HT8_MAX_BITS = 11;
    localparam int HT8_LINBITS  = 0;
    localparam int HT8_DIM      = 6;   // |x|,|y| in 0..5
    localparam int HT8_MAX_ABS  = HT8_DIM - 1;
    localparam int HT8_LEN_W    = 4;   // holds lengths 2..11

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CODE  = 2'd1,
        XSIGN = 2'd2,
        YSIGN = 2'd3
    } ht8_state_t;

    // Codewords, right-aligned; the significant width is the matching HT8_LEN.
    localparam logic [HT8_MAX_BITS-1:0] HT8_CODE [HT8_DIM*HT8_DIM] = '{
        11'd3,  11'd4,  11'd6,  11'd18, 11'd12, 11'd5,
        11'd5,  11'd1,  11'd2,  11'd16, 11'd9,  11'd3,
        11'd7,  11'd3,  11'd5,  11'd14, 11'd7,  11'd3,
        11'd19, 11'd17, 11'd15, 11'd13, 11'd10, 11'd4,
        11'd13, 11'd5,  11'd8,  11'd11, 11'd5,  11'd1,
        11'd12, 11'd4,  11'd4,  11'd1,  11'd1,  11'd0
    };

    localparam logic [HT8_LEN_W-1:0] HT8_LEN [HT8_DIM*HT8_DIM] = '{
        4'd2, 4'd3, 4'd6, 4'd8, 4'd8,  4'd9,
        4'd3, 4'd2, 4'd4, 4'd8, 4'd8,  4'd8,
        4'd6, 4'd4, 4'd6, 4'd8, 4'd8,  4'd9,
        4'd8, 4'd8, 4'd8, 4'd9, 4'd9,  4'd10,
        4'd8, 4'd7, 4'd8, 4'd9, 4'd10, 4'd10,
        4'd9, 4'd8, 4'd9, 4'd9, 4'd11, 4'd11
    };

    function automatic logic [5:0] ht8_index(input logic [2:0] ax, input logic [2:0] ay);
        return 6'(ax) * 6'(HT8_DIM) + 6'(ay);
    endfunction

endpackage

// File: rtl/ht_08_enc_lut.sv
// -----------------------------------------------------------------------------
// ht_08_enc_lut
// Combinational table-8 lookup: magnitudes in, codeword and its length out.
//   ax   : |x|, 0..5
//   ay   : |y|, 0..5
//   code : codeword, right-aligned in MAX_BITS
//   len  : codeword length in bits (2..11); 0 for magnitudes outside the table
// -----------------------------------------------------------------------------
module ht_08_enc_lut
    import ht_pkg::*;
#(
    parameter int MAX_BITS = HT8_MAX_BITS
) (
    input  logic [2:0]           ax,
    input  logic [2:0]           ay,
    output logic [MAX_BITS-1:0]  code,
    output logic [HT8_LEN_W-1:0] len
);

    // NOTE: every output gets a default before the conditional so no path
    // leaves it unassigned, which keeps this block purely combinational.
    always_comb begin
        code = '0;
        len  = '0;
        if (ax <= 3'(HT8_MAX_ABS) && ay <= 3'(HT8_MAX_ABS)) begin
            code = MAX_BITS'(HT8_CODE[ht8_index(ax, ay)]);
            len  = HT8_LEN[ht8_index(ax, ay)];
        end
    end

endmodule

// File: rtl/ht_08_encoder.sv
// -----------------------------------------------------------------------------
// ht_08_encoder
// Bit-serial Huffman table-8 encoder for one (x,y) pair at a time: emits the
// codeword MSB first, then the x sign bit (if x!=0), then the y sign bit
// (if y!=0). Out-of-range pairs are dropped with a one-cycle err pulse.
//   clk   : clock, all logic on rising edge
//   rst   : synchronous active-high reset
//   axiiv : input pair valid          axiir : ready for a new pair (IDLE only)
//   x_in  : signed x value            y_in  : signed y value
//   axiov : serial bit valid          axiod : serial bit
//   axior : downstream ready (bit moves when axiov && axior)
//   err   : pulse the cycle after an out-of-range pair handshake
// -----------------------------------------------------------------------------
module ht_08_encoder
    import ht_pkg::*;
#(
    parameter int MAX_BITS = HT8_MAX_BITS,
    parameter int LINBITS  = HT8_LINBITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               axiiv,
    input  logic signed [15:0] x_in,
    input  logic signed [15:0] y_in,
    output logic               axiir,
    output logic               axiov,
    output logic               axiod,
    input  logic               axior,
    output logic               err
);

    // Parameter sanity: the length field is 4 bits wide and table 8 has no
    // linbit escape, so anything else is a configuration mistake.
    if (MAX_BITS < HT8_MAX_BITS || MAX_BITS > 15) begin : g_bad_max_bits
        $error("ht_08_encoder: MAX_BITS must be in %0d..15", HT8_MAX_BITS);
    end
    if (LINBITS != 0) begin : g_bad_linbits
        $error("ht_08_encoder: table 8 has no linbits");
    end

    ht8_state_t state_q, state_d;

    logic                 x_ok, y_ok, in_range;
    logic [2:0]           ax, ay;
    logic [MAX_BITS-1:0]  lut_code;
    logic [HT8_LEN_W-1:0] lut_len;

    logic                 accept, drop;
    logic [MAX_BITS-1:0]  code_q;   // codeword, left-aligned, shifted out MSB first
    logic [HT8_LEN_W-1:0] len_q;
    logic [HT8_LEN_W-1:0] cnt_q;    // index of the codeword bit on axiod
    logic                 xnz_q, ynz_q, xsg_q, ysg_q;
    logic                 last_code_bit;

    // ---------------- input qualification ----------------
    assign x_ok     = (x_in >= -16'sd5) && (x_in <= 16'sd5);
    assign y_ok     = (y_in >= -16'sd5) && (y_in <= 16'sd5);
    assign in_range = x_ok && y_ok;

    // Magnitude from the low bits only: for in-range values the low three
    // bits of -v equal (0 - v[2:0]) mod 8, so the upper bits are not needed.
    assign ax = x_in[15] ? (3'd0 - x_in[2:0]) : x_in[2:0];
    assign ay = y_in[15] ? (3'd0 - y_in[2:0]) : y_in[2:0];

    ht_08_enc_lut #(
        .MAX_BITS (MAX_BITS)
    ) u_lut (
        .ax   (ax),
        .ay   (ay),
        .code (lut_code),
        .len  (lut_len)
    );

    assign accept        = axiir && axiiv && in_range;
    assign drop          = axiir && axiiv && !in_range;
    assign last_code_bit = (cnt_q == len_q - 4'd1);

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_d = state_q;
        axiir   = 1'b0;
        axiov   = 1'b0;
        axiod   = 1'b0;
        case (state_q)
            IDLE: begin
                axiir = 1'b1;
                if (axiiv && in_range) begin
                    state_d = CODE;
                end
            end
            CODE: begin
                axiov = 1'b1;
                axiod = code_q[MAX_BITS-1];
                if (axior && last_code_bit) begin
                    if (xnz_q) begin
                        state_d = XSIGN;
                    end else if (ynz_q) begin
                        state_d = YSIGN;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            XSIGN: begin
                axiov = 1'b1;
                axiod = xsg_q;
                if (axior) begin
                    state_d = ynz_q ? YSIGN : IDLE;
                end
            end
            YSIGN: begin
                axiov = 1'b1;
                axiod = ysg_q;
                if (axior) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------- error pulse ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= drop;
        end
    end

    // ---------------- pair datapath ----------------
    // NOTE: these registers carry no reset; they are always loaded on accept
    // before the FSM leaves IDLE, and reset already forces IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            code_q <= lut_code << (MAX_BITS - int'(lut_len));
            len_q  <= lut_len;
            cnt_q  <= '0;
            xnz_q  <= (ax != 3'd0);
            ynz_q  <= (ay != 3'd0);
            xsg_q  <= x_in[15];
            ysg_q  <= y_in[15];
        end else if (state_q == CODE && axior) begin
            code_q <= code_q << 1;
            if (!last_code_bit) begin
                cnt_q <= cnt_q + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_ht_08_encoder.sv
// -----------------------------------------------------------------------------
// tb_ht_08_encoder
// Directed bench for ht_08_encoder: a vector table of pairs with hand-computed
// bitstreams, hand-written stall / error / reset sequences, and a loopback of
// all 121 in-range pairs through a bench-side table-8 decoder.
// -----------------------------------------------------------------------------
module tb_ht_08_encoder;

    logic               clk = 1'b0;
    logic               rst;
    logic               axiiv;
    logic signed [15:0] x_in;
    logic signed [15:0] y_in;
    logic               axiir;
    logic               axiov;
    logic               axiod;
    logic               axior;
    logic               err;

    always #5 clk = ~clk;

    ht_08_encoder dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .x_in  (x_in),
        .y_in  (y_in),
        .axiir (axiir),
        .axiov (axiov),
        .axiod (axiod),
        .axior (axior),
        .err   (err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Independent copy of table 8 used only by the bench decoder.
    int tb_code [36] = '{3, 4, 6, 18, 12, 5,   5, 1, 2, 16, 9, 3,
                         7, 3, 5, 14, 7, 3,    19, 17, 15, 13, 10, 4,
                         13, 5, 8, 11, 5, 1,   12, 4, 4, 1, 1, 0};
    int tb_len  [36] = '{2, 3, 6, 8, 8, 9,     3, 2, 4, 8, 8, 8,
                         6, 4, 6, 8, 8, 9,     8, 8, 8, 9, 9, 10,
                         8, 7, 8, 9, 10, 10,   9, 8, 9, 9, 11, 11};

    // Collected bitstream of the most recent pair, first bit at index 0.
    logic rx_bits [16];
    int   rx_n;
    bit   rx_first;
    bit   rx_to;

    typedef struct {
        int          x;
        int          y;
        int          n;
        logic [15:0] bits;   // expected stream, right-aligned, first bit is MSB
    } vec_t;

    vec_t vecs [12];

    task automatic send(input int x, input int y);
        @(negedge clk);
        x_in  = 16'(x);
        y_in  = 16'(y);
        axiiv = 1'b1;
        @(negedge clk);
        axiiv = 1'b0;
    endtask

    // Called on the negedge right after acceptance; gathers bits until axiov drops.
    task automatic collect(input bit stall);
        rx_n     = 0;
        rx_first = (axiov === 1'b1);
        rx_to    = 1'b1;
        for (int c = 0; c < 400; c++) begin
            axior = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (axiov !== 1'b1) begin
                rx_to = 1'b0;
                break;
            end
            if (axior) begin
                if (rx_n < 16) rx_bits[rx_n] = axiod;
                rx_n++;
            end
            @(negedge clk);
        end
        axior = 1'b1;
    endtask

    function automatic logic [15:0] rx_value();
        logic [15:0] v = '0;
        for (int k = 0; k < rx_n && k < 16; k++) v = {v[14:0], rx_bits[k]};
        return v;
    endfunction

    // Table-8 decoder over rx_bits: returns decoded pair and whether exactly
    // rx_n bits were consumed.
    task automatic decode(output int dx, output int dy, output bit ok);
        int pos;
        dx = 99;
        dy = 99;
        ok = 1'b0;
        for (int a = 0; a < 6; a++) begin
            for (int b = 0; b < 6; b++) begin
                int  len  = tb_len[a*6+b];
                int  code = tb_code[a*6+b];
                bit  hit  = (len <= rx_n) && (rx_n <= 16);
                for (int k = 0; k < len && hit; k++) begin
                    if (rx_bits[k] !== 1'((code >> (len - 1 - k)) & 1)) hit = 1'b0;
                end
                if (hit) begin
                    pos = len;
                    dx  = a;
                    dy  = b;
                    if (a != 0 && pos < rx_n) begin
                        if (rx_bits[pos] === 1'b1) dx = -a;
                        pos++;
                    end
                    if (b != 0 && pos < rx_n) begin
                        if (rx_bits[pos] === 1'b1) dy = -b;
                        pos++;
                    end
                    ok = (pos == rx_n);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dx, dy;
        bit ok;

        vecs[0]  = '{0,  0,  2,  16'b11};
        vecs[1]  = '{1,  -1, 4,  16'b0101};
        vecs[2]  = '{-2, 1,  6,  16'b001110};
        vecs[3]  = '{5,  5,  13, 16'b0000000000000};
        vecs[4]  = '{1,  0,  4,  16'b1010};
        vecs[5]  = '{0,  1,  4,  16'b1000};
        vecs[6]  = '{-5, -5, 13, 16'b0000000000011};
        vecs[7]  = '{0,  -3, 9,  16'b000100101};
        vecs[8]  = '{3,  -2, 10, 16'b0000111101};
        vecs[9]  = '{-4, 0,  9,  16'b000011011};
        vecs[10] = '{2,  2,  8,  16'b00010100};
        vecs[11] = '{-1, 5,  10, 16'b0000001110};

        rst   = 1'b1;
        axiiv = 1'b0;
        axior = 1'b1;
        x_in  = '0;
        y_in  = '0;
        repeat (3) @(negedge clk);
        check("reset axiov", 32'(axiov), 0);
        check("reset axiod", 32'(axiod), 0);
        check("reset err",   32'(err),   0);
        check("reset axiir", 32'(axiir), 1);

        // No acceptance while rst is high.
        x_in  = 16'sd1;
        y_in  = 16'sd1;
        axiiv = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        axiiv = 1'b0;
        check("no accept in rst axiov", 32'(axiov), 0);
        check("no accept in rst axiir", 32'(axiir), 1);
        @(negedge clk);
        check("no accept in rst later", 32'(axiov), 0);

        // Table-driven vectors, downstream always ready.
        foreach (vecs[i]) begin
            send(vecs[i].x, vecs[i].y);
            collect(1'b0);
            check($sformatf("vec%0d (%0d,%0d) latency", i, vecs[i].x, vecs[i].y), 32'(rx_first), 1);
            check($sformatf("vec%0d timeout", i), 32'(rx_to), 0);
            check($sformatf("vec%0d nbits", i), 32'(rx_n), 32'(vecs[i].n));
            check($sformatf("vec%0d bits", i), 32'(rx_value()), 32'(vecs[i].bits));
            check($sformatf("vec%0d axiir after", i), 32'(axiir), 1);
        end

        // Stall: (0,1), first bit moves, then axior low for 3 cycles.
        send(0, 1);
        axior = 1'b1;
        check("stall first valid", 32'(axiov), 1);
        check("stall first bit",   32'(axiod), 1);
        @(negedge clk);
        axior = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall hold%0d valid", k), 32'(axiov), 1);
            check($sformatf("stall hold%0d bit", k),   32'(axiod), 0);
            @(negedge clk);
        end
        collect(1'b0);
        check("stall rest nbits", 32'(rx_n), 3);
        check("stall rest bits",  32'(rx_value()), 0);

        // Out-of-range pairs: err pulse, no bits, back to ready.
        foreach (vecs[i]) begin
            if (i < 3) begin
                int bx = (i == 0) ? 6 : (i == 1) ? 3 : -32768;
                int by = (i == 0) ? 0 : (i == 1) ? -6 : 0;
                send(bx, by);
                check($sformatf("range%0d err pulse", i), 32'(err), 1);
                check($sformatf("range%0d axiov", i), 32'(axiov), 0);
                @(negedge clk);
                check($sformatf("range%0d err clear", i), 32'(err), 0);
                check($sformatf("range%0d axiov later", i), 32'(axiov), 0);
                check($sformatf("range%0d axiir", i), 32'(axiir), 1);
            end
        end
        send(1, 0);
        collect(1'b0);
        check("after err nbits", 32'(rx_n), 4);
        check("after err bits",  32'(rx_value()), 32'b1010);

        // Reset while the 5th bit of (5,5) is on the output.
        send(5, 5);
        repeat (4) @(negedge clk);
        check("midword valid before rst", 32'(axiov), 1);
        rst = 1'b1;
        @(negedge clk);
        check("midword rst axiov", 32'(axiov), 0);
        check("midword rst axiod", 32'(axiod), 0);
        check("midword rst axiir", 32'(axiir), 1);
        check("midword rst err",   32'(err),   0);
        rst = 1'b0;
        @(negedge clk);
        check("midword after axiov", 32'(axiov), 0);
        send(0, 0);
        collect(1'b0);
        check("restart nbits", 32'(rx_n), 2);
        check("restart bits",  32'(rx_value()), 32'b11);

        // Loopback of every in-range pair with random back-pressure.
        for (int x = -5; x <= 5; x++) begin
            for (int y = -5; y <= 5; y++) begin
                send(x, y);
                collect(1'b1);
                decode(dx, dy, ok);
                check($sformatf("loop (%0d,%0d) x", x, y), 32'(dx), 32'(x));
                check($sformatf("loop (%0d,%0d) y", x, y), 32'(dy), 32'(y));
                check($sformatf("loop (%0d,%0d) length", x, y), 32'(ok && !rx_to), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
